// File: rtl/crc3_checker.sv
// crc3_checker: receive-side CRC-3 checker for 9-bit codewords {data[5:0], crc[2:0]}.
// Divides the codeword serially (MSB first) by g(x) = x^3 + x + 1 and reports
// pass/fail, the syndrome and the recovered payload. The result is offered on
// out_valid/out_ready, and a saturating counter records how many codewords failed.
//
// Handshake semantics (both ports): a transfer happens on the rising clock edge
// where valid and ready are both 1. A source holds valid and its payload stable
// until that edge. in_ready is only ever 1 in IDLE, and there is no buffering,
// so while the checker is busy the source must keep waiting. out_valid and the
// result fields stay stable until the consumer accepts them with out_ready.
module crc3_checker #(
  parameter int                    DATA_W   = 6,
  parameter int                    CRC_W    = 3,
  parameter logic [CRC_W-1:0]      POLY     = 3'b011,
  parameter int                    ERRCNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W+CRC_W-1:0]  in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_ok,
  output logic [CRC_W-1:0]         out_syndrome,
  output logic [DATA_W-1:0]        out_data,
  output logic [ERRCNT_W-1:0]      err_count,
  input  logic                     clr_err,
  output logic [1:0]               dbg_state
);

  localparam int CW    = DATA_W + CRC_W;
  localparam int CNT_W = $clog2(CW);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CW - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state;
  logic [CW-1:0]      sreg;
  logic [DATA_W-1:0]  data_q;
  logic [CRC_W-1:0]   rem;
  logic [CNT_W-1:0]   cnt;

  logic               cur_bit;
  logic [CRC_W-1:0]   rem_next;
  logic               last_bit;
  logic               accept;

  assign dbg_state = state;

  // Long-division step: bring the next codeword bit into the remainder and
  // subtract g(x) whenever the bit shifted out at x^3 was set. After all CW
  // bits the remainder is exactly codeword mod g(x), so a lone error in the
  // last crc bit yields syndrome 3'b001.
  always_comb begin
    cur_bit  = sreg[CW-1];
    rem_next = {rem[CRC_W-2:0], cur_bit} ^ (rem[CRC_W-1] ? POLY : '0);
    last_bit = (state == SHIFT) && (cnt == LAST_CNT);
    accept   = (state == IDLE) && in_valid && in_ready;
  end

  // Control FSM with registered handshake flags and result fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      sreg         <= '0;
      data_q       <= '0;
      rem          <= '0;
      cnt          <= '0;
      in_ready     <= 1'b0;
      out_valid    <= 1'b0;
      out_ok       <= 1'b0;
      out_syndrome <= '0;
      out_data     <= '0;
    end else begin
      case (state)
        IDLE: begin
          // in_ready rises on the first edge after reset release and stays up in IDLE.
          in_ready <= 1'b1;
          if (accept) begin
            sreg     <= in_data;
            data_q   <= in_data[CW-1:CRC_W];
            rem      <= '0;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          rem  <= rem_next;
          sreg <= {sreg[CW-2:0], 1'b0};
          cnt  <= cnt + 1'b1;
          if (last_bit) begin
            out_syndrome <= rem_next;
            out_ok       <= (rem_next == '0);
            out_data     <= data_q;
            out_valid    <= 1'b1;
            state        <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  // Saturating count of failed codewords; a clear wins over a same-edge increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (clr_err) begin
      err_count <= '0;
    end else if (last_bit && (rem_next != '0) && (err_count != '1)) begin
      err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_crc3_checker.sv
// tb_crc3_checker: directed self-checking bench for crc3_checker.
module tb_crc3_checker;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [8:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_ok;
  logic [2:0] out_syndrome;
  logic [5:0] out_data;
  logic [7:0] err_count;
  logic       clr_err;
  logic [1:0] dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  crc3_checker dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_ok       (out_ok),
    .out_syndrome (out_syndrome),
    .out_data     (out_data),
    .err_count    (err_count),
    .clr_err      (clr_err),
    .dbg_state    (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard check
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // drive a codeword and return #1 after the accepting edge
  task automatic send(input logic [8:0] d);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) check_eq("send_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // count edges from acceptance until out_valid rises
  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!out_valid) check_eq("valid_timeout", 32'd0, 32'd1);
  endtask

  // accept the pending result in one cycle
  task automatic take_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  // stimulus
  initial begin
    int   cyc;
    logic stable;
    logic seen;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    clr_err   = 1'b0;
    #12;
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_err_count", 32'(err_count), 32'd0);
    check_eq("rst_out_data",  32'(out_data),  32'd0);
    check_eq("rst_syndrome",  32'(out_syndrome), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);

    // 1: valid codeword 100000_010
    send(9'b100000_010);
    wait_valid(cyc);
    check_eq("t1_latency",  32'(cyc), 32'd9);
    check_eq("t1_ok",       32'(out_ok), 32'd1);
    check_eq("t1_syndrome", 32'(out_syndrome), 32'd0);
    check_eq("t1_data",     32'(out_data), 32'h20);
    check_eq("t1_in_ready", 32'(in_ready), 32'd0);
    take_result();
    check_eq("t1_err_count", 32'(err_count), 32'd0);
    check_eq("t1_released",  32'(out_valid), 32'd0);
    check_eq("t1_hold_data", 32'(out_data), 32'h20);

    // 2: valid codeword 110101_111
    send(9'b110101_111);
    wait_valid(cyc);
    check_eq("t2_ok",       32'(out_ok), 32'd1);
    check_eq("t2_syndrome", 32'(out_syndrome), 32'd0);
    check_eq("t2_data",     32'(out_data), 32'h35);
    take_result();

    // 3: crc bit0 flipped
    send(9'b100000_011);
    wait_valid(cyc);
    check_eq("t3_ok",        32'(out_ok), 32'd0);
    check_eq("t3_syndrome",  32'(out_syndrome), 32'd1);
    check_eq("t3_data",      32'(out_data), 32'h20);
    check_eq("t3_err_count", 32'(err_count), 32'd1);
    take_result();

    // 4: backpressure, second codeword waits at the input
    send(9'b110101_111);
    wait_valid(cyc);
    in_valid = 1'b1;
    in_data  = 9'b100000_010;
    stable   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (!out_valid || out_data !== 6'h35 || out_ok !== 1'b1 ||
          out_syndrome !== 3'd0 || in_ready !== 1'b0) stable = 1'b0;
    end
    check_eq("t4_stable", 32'(stable), 32'd1);
    check_eq("t4_state_done", 32'(dbg_state), 32'd2);
    take_result();
    check_eq("t4_in_ready_back", 32'(in_ready), 32'd1);
    send(9'b100000_010);
    wait_valid(cyc);
    check_eq("t4_second_data", 32'(out_data), 32'h20);
    check_eq("t4_second_ok",   32'(out_ok), 32'd1);
    take_result();

    // 5: reset during SHIFT cycle 4
    send(9'b110101_111);
    repeat (3) begin @(posedge clk); #1; end
    check_eq("t5_in_shift", 32'(dbg_state), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("t5_out_valid", 32'(out_valid), 32'd0);
    check_eq("t5_out_data",  32'(out_data), 32'd0);
    check_eq("t5_syndrome",  32'(out_syndrome), 32'd0);
    check_eq("t5_err_count", 32'(err_count), 32'd0);
    check_eq("t5_state",     32'(dbg_state), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("t5_in_ready", 32'(in_ready), 32'd1);
    seen = 1'b0;
    repeat (14) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check_eq("t5_no_result", 32'(seen), 32'd0);

    // 6: saturation and clear priority
    for (int i = 0; i < 256; i++) begin
      send(9'b100000_011);
      wait_valid(cyc);
      take_result();
    end
    check_eq("t6_saturated", 32'(err_count), 32'hFF);
    send(9'b100000_011);
    wait_valid(cyc);
    take_result();
    check_eq("t6_still_sat", 32'(err_count), 32'hFF);
    send(9'b100000_011);
    repeat (8) begin @(posedge clk); #1; end
    check_eq("t6_pre_done", 32'(out_valid), 32'd0);
    clr_err = 1'b1;
    @(posedge clk); #1;
    clr_err = 1'b0;
    check_eq("t6_done_now", 32'(out_valid), 32'd1);
    check_eq("t6_clr_wins", 32'(err_count), 32'd0);
    take_result();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
